imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Loader bus: session control, byte-stream handshake and instruction-memory write port.
// master = stream source / session controller, slave = the loader.
interface imem_loader_if #(parameter int ADDR_W = 10);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (output start, rx_valid, rx_data,
                    input  rx_ready, we, waddr, wdata, busy, done, err);
    modport slave  (input  start, rx_valid, rx_data,
                    output rx_ready, we, waddr, wdata, busy, done, err);
endinterface

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: 4-byte LE word count, then N LE words.
// Define IMEM_LOADER_CSUM_EN to require a trailing 4-byte LE sum-of-words checksum.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
`ifdef IMEM_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, FIN} state_t;
`endif

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic        active;
    logic        xfer;
    logic [31:0] word;

    always_comb begin
        active = (state_q == LEN) || (state_q == DATA);
`ifdef IMEM_LOADER_CSUM_EN
        active = active || (state_q == CHK);
`endif
    end

    assign xfer = bus.rx_valid && active;
    // Bytes shift in from the top so the first byte lands in [7:0] after four.
    assign word = {bus.rx_data, asm_q[31:8]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        idx_d      = idx_q;
        last_d     = last_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d     = csum_q;
`endif
        if (xfer) begin
            asm_d      = word;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
        case (state_q)
            IDLE: if (bus.start) begin
                state_d    = LEN;
                done_d     = 1'b0;
                err_d      = 1'b0;
                idx_d      = '0;
                byte_cnt_d = '0;
                waddr_d    = '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum_d     = '0;
`endif
            end
            LEN: if (xfer && byte_cnt_q == 2'd3) begin
                if (word == 32'd0) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else if ({1'b0, word} > DEPTH) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = DATA;
                    last_d  = word[ADDR_W-1:0] - ADDR_W'(1);
                end
            end
            DATA: if (xfer && byte_cnt_q == 2'd3) begin
                // Write lands the following cycle; the next word may already be streaming.
                we_d    = 1'b1;
                wdata_d = word;
                waddr_d = idx_q;
                idx_d   = idx_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
                csum_d  = csum_q + word;
`endif
                if (idx_q == last_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = CHK;
`else
                    state_d = FIN;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CHK: if (xfer && byte_cnt_q == 2'd3) begin
                state_d = FIN;
                done_d  = 1'b1;
                err_d   = (word != csum_q);
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.rx_ready = active;
    assign bus.busy     = active;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
